// File: rtl/seq_scan_pkg.sv
// Shared types and default widths for the serial pattern-scan controller.
package seq_scan_pkg;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PAT_LEN = 4;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/seq_window.sv
// Sliding PAT_LEN-bit window with fill tracking and pattern compare.
// SEQ_SCAN_OVERLAP_EN keeps the window full after a hit so overlapping occurrences count.
module seq_window
    import seq_scan_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               bit_in,
    input  logic [PAT_LEN-1:0] pat_q,
    output logic               hit
);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] window_q, window_d;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;

    always_comb begin
        window_d = {window_q[PAT_LEN-2:0], bit_in};
        fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        hit      = shift && (fill_inc == FULL) && (window_d == pat_q);
`ifdef SEQ_SCAN_OVERLAP_EN
        fill_d   = fill_inc;
`else
        fill_d   = hit ? '0 : fill_inc;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (shift) begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end
endmodule

// File: rtl/seq_scan_ctrl.sv
// Serializes each accepted word MSB-first through seq_window and counts pattern hits.
// Build option SEQ_SCAN_OVERLAP_EN selects overlapping detection.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PAT_LEN-1:0] pat,
    input  logic               clr,
    output logic               match,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt
);
    localparam int BC_W = $clog2(DATA_W + 1);

    state_t             state_q;
    logic [DATA_W-1:0]  sreg_q;
    logic [PAT_LEN-1:0] pat_q;
    logic [BC_W-1:0]    bit_cnt_q;
    logic               match_q, done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               shift, hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign shift     = (state_q == SHIFT) && !clr;
    assign in_ready  = (state_q == IDLE);
    assign match     = match_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;

    seq_window #(.PAT_LEN(PAT_LEN)) u_window (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .shift  (shift),
        .bit_in (sreg_q[DATA_W-1]),
        .pat_q  (pat_q),
        .hit    (hit)
    );

    // Shift register and pattern latch are data-only and need no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid && !clr) begin
            sreg_q <= in_data;
            pat_q  <= pat;
        end else if (shift) begin
            sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (clr) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            match_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    match_q   <= hit;
                    if (hit) cnt_q <= sat_inc(cnt_q);
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
